// File: rtl/cpu_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response,
// decode-side instruction handoff and the stage-2 redirect.
// master = fetch unit, slave = surrounding memory/decode/branch logic.
interface cpu_fetch_if #(
    parameter int IADDRWIDTH = 16,
    parameter int IWIDTH     = 16
);
    // memory request channel
    logic                  ireq_valid;
    logic [IADDRWIDTH-1:0] ireq_addr;
    logic                  ireq_ready;
    // memory response channel (in order, no backpressure)
    logic                  iresp_valid;
    logic [IWIDTH-1:0]     iresp_data;
    // instruction handoff to decode
    logic                  ir_valid;
    logic [IWIDTH-1:0]     ir_data;
    logic [IADDRWIDTH-1:0] ir_pc;
    logic                  ir_ready;
    // branch / flush from stage 2
    logic                  redirect;
    logic [IADDRWIDTH-1:0] redirect_pc;

    modport master (
        output ireq_valid, ireq_addr, ir_valid, ir_data, ir_pc,
        input  ireq_ready, iresp_valid, iresp_data, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, ir_valid, ir_data, ir_pc,
        output ireq_ready, iresp_valid, iresp_data, ir_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction prefetch unit.
// Issues sequential fetches, buffers in-order responses in a DEPTH-entry
// circular FIFO tagged with their PC, and handles redirects by flushing the
// buffer and discarding responses to requests issued before the redirect.
// Requests are throttled so inflight + occupancy never exceeds DEPTH, hence
// every response always has a slot and memory never needs backpressure.
// Optional feature: define CPU_FETCH_BYPASS_EN to forward a response straight
// to decode in the cycle it arrives when the buffer is empty.
module cpu_fetch #(
    parameter int                    IADDRWIDTH = 16,
    parameter int                    IWIDTH     = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [IADDRWIDTH-1:0] RESET_PC   = '0
) (
    input  logic         clk,
    input  logic         rst,    // active-low, asynchronous
    cpu_fetch_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    typedef logic [IADDRWIDTH-1:0] addr_t;
    typedef struct packed {
        logic [IWIDTH-1:0] data;
        addr_t             pc;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   infl_q, infl_d;
    logic [CW-1:0]   drop_q, drop_d;
    addr_t           fpc_q, fpc_d;
    addr_t           rpc_q, rpc_d;

    logic            req_ok, req_xfer;
    logic            resp_keep, nonempty, byp, push, pop;
    logic [CW:0]     occ;
    entry_t          head;

    assign head     = fifo_q[rptr_q];
    assign nonempty = (count_q != '0);
    assign occ      = {1'b0, infl_q} + {1'b0, count_q};

    // Request gating, response acceptance and FIFO push/pop decisions
    always_comb begin
        // rst gates outputs combinationally so nothing is offered while held in reset
        req_ok    = rst && !bus.redirect && (occ < DEPTH_W);
        req_xfer  = req_ok && bus.ireq_ready;
        // a response is kept only outside redirect cycles and once all stale words are gone
        resp_keep = rst && bus.iresp_valid && !bus.redirect && (drop_q == '0);
`ifdef CPU_FETCH_BYPASS_EN
        byp       = resp_keep && !nonempty;
`else
        byp       = 1'b0;
`endif
        pop       = nonempty && bus.ir_ready && !bus.redirect;
        // a bypassed word that decode takes immediately never touches the FIFO
        push      = resp_keep && !(byp && bus.ir_ready);
    end

    // Output drive: FIFO head, or the arriving response when bypassing
    always_comb begin
        bus.ireq_valid = req_ok;
        bus.ireq_addr  = fpc_q;
        bus.ir_valid   = nonempty || byp;
        bus.ir_data    = head.data;
        bus.ir_pc      = head.pc;
        if (byp) begin
            bus.ir_data = bus.iresp_data;
            bus.ir_pc   = rpc_q;
        end
    end

    // Next-state for PCs, counters and pointers; redirect overrides all
    always_comb begin
        fpc_d   = req_xfer ? fpc_q + addr_t'(1) : fpc_q;
        rpc_d   = resp_keep ? rpc_q + addr_t'(1) : rpc_q;
        infl_d  = infl_q + CW'(req_xfer) - CW'(bus.iresp_valid);
        drop_d  = drop_q;
        if (bus.iresp_valid && (drop_q != '0))
            drop_d = drop_q - CW'(1);
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (bus.redirect) begin
            fpc_d   = bus.redirect_pc;
            rpc_d   = bus.redirect_pc;
            // every request still outstanding after this cycle belongs to the old path
            drop_d  = infl_q - CW'(bus.iresp_valid);
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            infl_q  <= '0;
            drop_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            infl_q  <= infl_d;
            drop_q  <= drop_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Buffer storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wptr_q] <= '{data: bus.iresp_data, pc: rpc_q};
    end
endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch. A fixed-latency in-order memory model
// returns data = memf(addr); a reference model tracks outstanding requests
// (with their addresses), the decode-visible buffer contents and the number
// of stale responses to throw away after a redirect.
module tb_cpu_fetch;
    localparam int          AW       = 16;
    localparam int          DW       = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef CPU_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_fetch_if #(.IADDRWIDTH(AW), .IWIDTH(DW)) bus();

    cpu_fetch #(.IADDRWIDTH(AW), .IWIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mreq_t       mq[$];
    logic [15:0] fq[$];
    logic [15:0] iss_log[$];
    logic [15:0] con_log[$];
    int          drop, cyc, lat, rdy_mode, irr_mode;
    logic [15:0] fpc, redir_pc;
    bit          redir_req, s_irv;
    int          n_chk, n_fail;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
    endfunction

    function automatic bit pick(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return mode != 0;
    endfunction

    // One clock cycle: starts and ends at a negedge.
    task automatic cycle();
        bit          rv, rd, ireqr, irr, acc, exp_v, consume, was_empty, exp_rq;
        logic [15:0] ra, exp_pc;
        int          outst;
        mreq_t       nr;
        rv = 1'b0; ra = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin rv = 1'b1; ra = mq[0].addr; end
        outst = mq.size();
        if (rv) void'(mq.pop_front());
        ireqr = pick(rdy_mode);
        irr   = pick(irr_mode);
        rd    = redir_req;
        redir_req = 1'b0;
        bus.iresp_valid = rv;
        bus.iresp_data  = rv ? memf(ra) : 16'($urandom);
        bus.ireq_ready  = ireqr;
        bus.ir_ready    = irr;
        bus.redirect    = rd;
        bus.redirect_pc = rd ? redir_pc : 16'($urandom);
        #1;
        acc = rv && !rd && (drop == 0);
        exp_v = 1'b0; exp_pc = '0;
        if (fq.size() > 0) begin exp_v = 1'b1; exp_pc = fq[0]; end
        else if (BYP && acc) begin exp_v = 1'b1; exp_pc = ra; end
        s_irv = bus.ir_valid;
        n_chk++;
        if (bus.ir_valid !== exp_v) begin
            n_fail++; $display("FAIL ir_valid cyc=%0d got=%b exp=%b", cyc, bus.ir_valid, exp_v);
        end
        if (exp_v) begin
            n_chk++;
            if (bus.ir_pc !== exp_pc) begin
                n_fail++; $display("FAIL ir_pc cyc=%0d got=%h exp=%h", cyc, bus.ir_pc, exp_pc);
            end
            n_chk++;
            if (bus.ir_data !== memf(exp_pc)) begin
                n_fail++; $display("FAIL ir_data cyc=%0d got=%h exp=%h", cyc, bus.ir_data, memf(exp_pc));
            end
        end
        exp_rq = !rd && (outst + fq.size() < DEPTH);
        n_chk++;
        if (bus.ireq_valid !== exp_rq) begin
            n_fail++; $display("FAIL ireq_valid cyc=%0d got=%b exp=%b", cyc, bus.ireq_valid, exp_rq);
        end
        if (exp_rq) begin
            n_chk++;
            if (bus.ireq_addr !== fpc) begin
                n_fail++; $display("FAIL ireq_addr cyc=%0d got=%h exp=%h", cyc, bus.ireq_addr, fpc);
            end
        end
        if (bus.ireq_valid === 1'b1 && ireqr) iss_log.push_back(bus.ireq_addr);
        if (bus.ir_valid === 1'b1 && irr && !rd) con_log.push_back(bus.ir_pc);
        // advance the reference model
        consume   = exp_v && irr && !rd;
        was_empty = (fq.size() == 0);
        if (rd) begin
            fq.delete();
            drop = mq.size();
            fpc  = redir_pc;
        end else begin
            if (consume && !was_empty) void'(fq.pop_front());
            if (rv && drop > 0) drop--;
            else if (acc && !(consume && was_empty)) fq.push_back(ra);
        end
        if (exp_rq && ireqr) begin
            nr.addr = fpc; nr.due = cyc + lat;
            mq.push_back(nr);
            fpc = fpc + 16'd1;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Hold reset for some cycles; memory model is reset alongside.
    task automatic do_reset(input int cycles);
        rst = 1'b0;
        bus.iresp_valid = 1'b0; bus.ireq_ready = 1'b0; bus.ir_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.iresp_data = '0;
        #1;
        n_chk++;
        if (bus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ireq_valid got=%b exp=0", bus.ireq_valid); end
        n_chk++;
        if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid got=%b exp=0", bus.ir_valid); end
        mq.delete(); fq.delete(); drop = 0; fpc = RESET_PC; redir_req = 1'b0;
        iss_log.delete(); con_log.delete();
        repeat (cycles) @(negedge clk);
        n_chk++;
        if (bus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ireq_valid got=%b exp=0", bus.ireq_valid); end
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(3);
        lat = 1; rdy_mode = 0; irr_mode = 0;
        cycle();   // first cycle after release: ireq_valid=1, addr=RESET_PC
    endtask

    task automatic test_stream();
        do_reset(2);
        lat = 1; rdy_mode = 1; irr_mode = 1;
        repeat (12) cycle();
        n_chk++;
        if (iss_log.size() != 12) begin n_fail++; $display("FAIL stream_issue_count got=%0d exp=12", iss_log.size()); end
        n_chk++;
        if (con_log.size() < 4) begin n_fail++; $display("FAIL stream_consume_count got=%0d exp>=4", con_log.size()); end
        for (int i = 0; i < 4 && i < con_log.size() && i < iss_log.size(); i++) begin
            n_chk++;
            if (iss_log[i] !== 16'(i)) begin n_fail++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, iss_log[i], 16'(i)); end
            n_chk++;
            if (con_log[i] !== 16'(i)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, con_log[i], 16'(i)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        lat = 1; rdy_mode = 1; irr_mode = 0;
        repeat (10) cycle();
        n_chk++;
        if (iss_log.size() != 4) begin n_fail++; $display("FAIL bp_issue_count got=%0d exp=4", iss_log.size()); end
        n_chk++;
        if (bus.ireq_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ireq_valid got=%b exp=0", bus.ireq_valid); end
        irr_mode = 1;
        repeat (8) cycle();
        n_chk++;
        if (con_log.size() < 4) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp>=4", con_log.size()); end
        for (int i = 0; i < 4 && i < con_log.size(); i++) begin
            n_chk++;
            if (con_log[i] !== 16'(i)) begin n_fail++; $display("FAIL bp_drain[%0d] got=%h exp=%h", i, con_log[i], 16'(i)); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(2);
        lat = 3; rdy_mode = 1; irr_mode = 1;
        repeat (3) cycle();   // 0,1,2 in flight
        redir_req = 1'b1; redir_pc = 16'h0100;
        iss_log.delete(); con_log.delete();
        cycle();
        repeat (12) cycle();
        n_chk++;
        if (iss_log.size() == 0 || iss_log[0] !== 16'h0100) begin
            n_fail++; $display("FAIL redir_first_addr got=%h exp=0100", iss_log.size() ? iss_log[0] : 16'hxxxx);
        end
        n_chk++;
        if (con_log.size() == 0 || con_log[0] !== 16'h0100) begin
            n_fail++; $display("FAIL redir_first_pc got=%h exp=0100", con_log.size() ? con_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_redirect_coincident();
        do_reset(2);
        lat = 2; rdy_mode = 1; irr_mode = 0;
        repeat (4) cycle();   // buffer holds 0,1; 2 arriving now; 3 outstanding
        irr_mode = 1;
        redir_req = 1'b1; redir_pc = 16'h0200;
        con_log.delete();
        cycle();              // redirect + response + ir_ready together
        cycle();              // stale word for 3 arrives and must vanish
        n_chk++;
        if (s_irv !== 1'b0) begin n_fail++; $display("FAIL coinc_flush ir_valid got=%b exp=0", s_irv); end
        repeat (8) cycle();
        n_chk++;
        if (con_log.size() == 0 || con_log[0] !== 16'h0200) begin
            n_fail++; $display("FAIL coinc_first_pc got=%h exp=0200", con_log.size() ? con_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_wrap();
        do_reset(2);
        lat = 1; rdy_mode = 1; irr_mode = 1;
        redir_req = 1'b1; redir_pc = 16'hFFFF;
        cycle();
        iss_log.delete(); con_log.delete();
        repeat (6) cycle();
        n_chk++;
        if (iss_log.size() < 2 || iss_log[0] !== 16'hFFFF || iss_log[1] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_addr got=%h,%h exp=ffff,0000",
                               iss_log.size() > 0 ? iss_log[0] : 16'hxxxx, iss_log.size() > 1 ? iss_log[1] : 16'hxxxx);
        end
        n_chk++;
        if (con_log.size() < 2 || con_log[0] !== 16'hFFFF || con_log[1] !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_pc got=%h,%h exp=ffff,0000",
                               con_log.size() > 0 ? con_log[0] : 16'hxxxx, con_log.size() > 1 ? con_log[1] : 16'hxxxx);
        end
    endtask

    task automatic test_latency();
        do_reset(2);
        lat = 2; rdy_mode = 1; irr_mode = 0;
        cycle();              // issue addr 0 in cycle 0
        rdy_mode = 0;
        cycle();              // cycle 1: nothing returns
        cycle();              // cycle 2: response arrives
        n_chk++;
        if (s_irv !== BYP) begin n_fail++; $display("FAIL lat_same_cycle ir_valid got=%b exp=%b", s_irv, BYP); end
        cycle();              // cycle 3
        n_chk++;
        if (s_irv !== 1'b1) begin n_fail++; $display("FAIL lat_next_cycle ir_valid got=%b exp=1", s_irv); end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(1 + int'($urandom_range(0, 2)));   // resets with traffic still in flight
            lat = int'($urandom_range(1, 4));
            rdy_mode = 2; irr_mode = 2;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    redir_req = 1'b1;
                    redir_pc  = 16'($urandom);
                end
                cycle();
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; drop = 0; lat = 1;
        rdy_mode = 0; irr_mode = 0; redir_req = 1'b0; redir_pc = '0; fpc = RESET_PC; s_irv = 1'b0;
        bus.iresp_valid = 1'b0; bus.ireq_ready = 1'b0; bus.ir_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.iresp_data = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_wrap();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
